npu_bus_master: RTL and testbench

Host-side initiator for the NPU's memory-mapped register port (ena/wea/addra/dina/douta). It accepts a stream of commands (register write, single read, poll-until-set), converts each into correctly timed bus cycles, and returns read/poll results on a response handshake. It sits between a CPU, DMA or testbench sequencer and the `npu` slave, so software never has to hand-time bus cycles.

---
 rtl/npu_bus_master.sv | 114 +++++++++++
 tb/tb_npu_bus_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_bus_master.sv
// npu_bus_master: turns WRITE/READ/POLL commands into paced NPU register-port
// cycles and returns read/poll results on a valid/ready response channel.
module npu_bus_master #(
  parameter int POLL_MAX = 1023,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_sel,
  input  logic [31:0] cmd_data,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, WR, GAP, RD_REQ, RD_WAIT, P_REQ, P_WAIT, RSP
  } state_t;

  state_t            state, state_n;
  logic [2:0]        sel_q;
  logic [31:0]       data_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept, hit, last_poll, bus_n, wr_n;
  logic [2:0]        sel_n;
  logic [31:0]       data_n;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign hit       = (douta & data_q) != 32'h0;
  assign last_poll = cnt == CNT_W'(POLL_MAX - 1);
  assign rsp_valid = state == RSP;
  assign busy      = state != IDLE;

  // On the accept edge the latches are not loaded yet, so bus fields come straight from the command.
  assign sel_n  = accept ? cmd_sel  : sel_q;
  assign data_n = accept ? cmd_data : data_q;
  assign bus_n  = state_n inside {WR, RD_REQ, P_REQ};
  assign wr_n   = state_n == WR;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00:   state_n = WR;
            2'b01:   state_n = RD_REQ;
            2'b10:   state_n = P_REQ;
            default: state_n = IDLE;
          endcase
        end
      end
      WR:      state_n = GAP;
      GAP:     state_n = IDLE;
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: state_n = RSP;
      P_REQ:   state_n = P_WAIT;
      P_WAIT:  state_n = (hit || last_poll) ? RSP : P_REQ;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Bus outputs are registered from the next state so they line up with WR/RD_REQ/P_REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= 3'd0;
      data_q   <= 32'h0;
      cnt      <= '0;
      ena      <= 1'b0;
      wea      <= 1'b0;
      addra    <= 16'h0;
      dina     <= 32'h0;
      rsp_data <= 32'h0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        sel_q  <= cmd_sel;
        data_q <= cmd_data;
        cnt    <= '0;
      end
      ena   <= bus_n;
      wea   <= wr_n;
      addra <= bus_n ? {1'b0, sel_n, 12'h000} : 16'h0;
      dina  <= wr_n ? data_n : 32'h0;
      if (state == RD_WAIT) begin
        rsp_data <= douta;
        rsp_err  <= 1'b0;
      end
      if (state == P_WAIT) begin
        rsp_data <= douta;
        rsp_err  <= !hit && last_poll;
        if (!hit && !last_poll) cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_npu_bus_master.sv
// tb_npu_bus_master: drives directed and random command streams into npu_bus_master
// against an NPU register-file model and a command-level reference.
module tb_npu_bus_master;
  localparam int PM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_sel;
  logic [31:0] cmd_data;
  logic        ena, wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta = 32'h0;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
  } bus_t;

  bus_t        bus_log[$];
  logic [31:0] read_q[$];
  logic [31:0] npu_mem[8];
  logic [31:0] ref_mem[8];
  logic        ena_prev = 1'b0;
  bit          rsp_seen = 0;
  int          last_acc, last_lat;
  logic [31:0] last_d;
  logic        last_e;

  npu_bus_master #(.POLL_MAX(PM), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // NPU slave: registered read data, optionally overridden by a scripted queue for polls.
  always @(posedge clk) begin
    if (ena) begin
      if (wea) npu_mem[addra[14:12]] <= dina;
      else if (read_q.size() > 0) douta <= read_q.pop_front();
      else douta <= npu_mem[addra[14:12]];
    end
  end

  always @(negedge clk) begin
    tests++;
    if (ena) begin
      if (ena_prev) begin
        fails++;
        $display("[TB] FAIL ena_consecutive: ena high two cycles in a row at cycle %0d", cyc);
      end
      bus_log.push_back('{cyc, wea, addra, dina});
    end else if (wea !== 1'b0 || addra !== 16'h0 || dina !== 32'h0) begin
      fails++;
      $display("[TB] FAIL idle_bus: wea=%b addra=%h dina=%h, required all 0", wea, addra, dina);
    end
    ena_prev = ena;
    if (rsp_valid) rsp_seen = 1;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] data,
                          output int acc);
    int guard = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = data;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      tests++; fails++;
      $display("[TB] FAIL accept_timeout: cmd_ready never rose, required within 100 cycles");
    end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output bit ok);
    ok = 0;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1; last_d = rsp_data; last_e = rsp_err; last_lat = cyc - acc + 1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("[TB] FAIL rsp_timeout: no rsp_valid within 60 cycles, required one");
    end
  endtask

  // Issue one command and check it against the command-level reference.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] data,
                         input int hold);
    logic [31:0] vals[$];
    logic [31:0] exp_d, v;
    logic        exp_e;
    int          exp_n, exp_lat, acc;
    bit          ok;
    exp_d = ref_mem[sel]; exp_e = 1'b0; exp_n = 1;
    if (op == 2'b10) begin
      vals = read_q;
      exp_n = PM; exp_e = 1'b1;
      for (int i = 0; i < PM; i++) begin
        v = (i < vals.size()) ? vals[i] : ref_mem[sel];
        exp_d = v;
        if ((v & data) != 32'h0) begin
          exp_n = i + 1; exp_e = 1'b0;
          break;
        end
      end
    end
    exp_lat = 2 * exp_n + 1;
    rsp_ready = (hold == 0);
    bus_log.delete();
    rsp_seen = 0;
    send_cmd(op, sel, data, acc);
    last_acc = acc;
    if (op == 2'b00) begin
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL wr_ready_early: got %b, required 0", cmd_ready); end
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL wr_ready_back: got %b, required 1", cmd_ready); end
      tests++;
      if (bus_log.size() != 1) begin
        fails++; $display("[TB] FAIL wr_count: got %0d bus cycles, required 1", bus_log.size());
      end else begin
        tests++;
        if (bus_log[0].c != acc || bus_log[0].w !== 1'b1 || bus_log[0].a !== {1'b0, sel, 12'h000}
            || bus_log[0].d !== data) begin
          fails++;
          $display("[TB] FAIL wr_cycle: got lat=%0d wea=%b addra=%h dina=%h, required lat=1 wea=1 addra=%h dina=%h",
                   bus_log[0].c - acc + 1, bus_log[0].w, bus_log[0].a, bus_log[0].d, {1'b0, sel, 12'h000}, data);
        end
      end
      tests++;
      if (rsp_seen) begin fails++; $display("[TB] FAIL wr_no_rsp: got rsp_valid, required none"); end
      ref_mem[sel] = data;
    end else if (op == 2'b11) begin
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        fails++; $display("[TB] FAIL nop_idle: got ready=%b busy=%b, required 1 0", cmd_ready, busy);
      end
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (bus_log.size() != 0 || rsp_seen) begin
        fails++; $display("[TB] FAIL nop_quiet: got %0d bus cycles rsp=%b, required 0 0", bus_log.size(), rsp_seen);
      end
    end else begin
      wait_rsp(acc, ok);
      if (ok) begin
        tests++;
        if (last_lat != exp_lat || last_d !== exp_d || last_e !== exp_e) begin
          fails++;
          $display("[TB] FAIL rsp: got lat=%0d data=%h err=%b, required lat=%0d data=%h err=%b",
                   last_lat, last_d, last_e, exp_lat, exp_d, exp_e);
        end
        for (int i = 1; i < hold; i++) begin
          @(negedge clk);
          tests++;
          if (rsp_valid !== 1'b1 || rsp_data !== last_d || rsp_err !== last_e) begin
            fails++;
            $display("[TB] FAIL rsp_hold: got valid=%b data=%h err=%b, required 1 %h %b",
                     rsp_valid, rsp_data, rsp_err, last_d, last_e);
          end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("[TB] FAIL rsp_release: got valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
      end
      tests++;
      if (bus_log.size() != exp_n) begin
        fails++; $display("[TB] FAIL rd_count: got %0d reads, required %0d", bus_log.size(), exp_n);
      end else begin
        foreach (bus_log[i]) begin
          tests++;
          if (bus_log[i].c != acc + 2 * i || bus_log[i].w !== 1'b0 || bus_log[i].a !== {1'b0, sel, 12'h000}) begin
            fails++;
            $display("[TB] FAIL rd_cycle: read %0d got lat=%0d wea=%b addra=%h, required lat=%0d wea=0 addra=%h",
                     i, bus_log[i].c - acc + 1, bus_log[i].w, bus_log[i].a, 2 * i + 1, {1'b0, sel, 12'h000});
          end
        end
      end
    end
    read_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({ena, wea, addra, dina, rsp_valid, rsp_data, rsp_err, busy, cmd_ready} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs: got nonzero outputs in reset, required all 0");
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_release: got ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    run_cmd(2'b00, 3'd4, 32'h1, 0);
    tests++;
    if (bus_log.size() != 1 || bus_log[0].a !== 16'h4000 || bus_log[0].d !== 32'h1) begin
      fails++; $display("[TB] FAIL write_sel4: got %0d cycles, required one at 4000 with data 1", bus_log.size());
    end
  endtask

  task automatic test_read();
    npu_mem[6] = 32'hDEADBEEF; ref_mem[6] = 32'hDEADBEEF;
    run_cmd(2'b01, 3'd6, 32'h0, 4);
    tests++;
    if (last_d !== 32'hDEADBEEF || bus_log.size() != 1 || bus_log[0].a !== 16'h6000) begin
      fails++; $display("[TB] FAIL read_sel6: got data=%h, required DEADBEEF at 6000", last_d);
    end
  endtask

  task automatic test_poll_success();
    npu_mem[7] = 32'h0; ref_mem[7] = 32'h0;
    read_q = '{32'h0, 32'h0, 32'h1};
    run_cmd(2'b10, 3'd7, 32'h1, 0);
    tests++;
    if (bus_log.size() != 3 || last_lat != 7 || last_d !== 32'h1 || last_e !== 1'b0) begin
      fails++; $display("[TB] FAIL poll_ok: got reads=%0d lat=%0d data=%h err=%b, required 3 7 1 0",
                        bus_log.size(), last_lat, last_d, last_e);
    end
  endtask

  task automatic test_poll_timeout();
    npu_mem[2] = 32'h0; ref_mem[2] = 32'h0;
    run_cmd(2'b10, 3'd2, $urandom | 32'h1, 2);
    tests++;
    if (bus_log.size() != PM || last_e !== 1'b1 || last_d !== 32'h0 || last_lat != 2 * PM + 1) begin
      fails++; $display("[TB] FAIL poll_timeout: got reads=%0d err=%b data=%h, required %0d 1 0",
                        bus_log.size(), last_e, last_d, PM);
    end
  endtask

  task automatic test_reset_mid_poll();
    int acc;
    npu_mem[3] = 32'h0; ref_mem[3] = 32'h0;
    rsp_ready = 1'b1;
    send_cmd(2'b10, 3'd3, 32'h1, acc);
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || ena !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_poll_state: got busy=%b ena=%b, required 1 0", busy, ena);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ena, wea, addra, dina, rsp_valid, rsp_data, rsp_err, busy, cmd_ready} !== '0) begin
      fails++; $display("[TB] FAIL mid_poll_reset: got nonzero outputs after rst, required all 0");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_seen = 0;
    bus_log.delete();
    repeat (8) @(negedge clk);
    tests++;
    if (rsp_seen || bus_log.size() != 0) begin
      fails++; $display("[TB] FAIL mid_poll_quiet: got rsp=%b bus=%0d, required 0 0", rsp_seen, bus_log.size());
    end
    npu_mem[5] = $urandom; ref_mem[5] = npu_mem[5];
    run_cmd(2'b01, 3'd5, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    int accs[5];
    for (int i = 0; i < 5; i++) begin
      run_cmd(2'b00, 3'($urandom_range(0, 7)), $urandom, 0);
      accs[i] = last_acc;
    end
    for (int i = 1; i < 5; i++) begin
      tests++;
      if (accs[i] - accs[i-1] != 3) begin
        fails++; $display("[TB] FAIL burst_spacing: got %0d cycles, required 3", accs[i] - accs[i-1]);
      end
    end
    run_cmd(2'b11, 3'($urandom_range(0, 7)), $urandom, 0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [2:0]  sel;
    logic [31:0] data;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      data = $urandom;
      if (op == 2'b10) begin
        data = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
        for (int k = 0; k < int'($urandom_range(0, 5)); k++)
          read_q.push_back($urandom_range(0, 1) ? 32'h0 : (32'h1 << $urandom_range(0, 31)));
      end
      run_cmd(op, sel, data, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_sel = 3'd0; cmd_data = 32'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin npu_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    #2 rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_poll_success();
    test_poll_timeout();
    test_reset_mid_poll();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
